mvm_seq_ctrl: RTL

- Sequencing controller for one matrix-vector multiply y = W*x on a single signed MAC pipeline (registered product stage, then an accumulate/saturate stage).
- Loads an M x N matrix and an N-element vector from an input stream into two single-port memories.
- Then walks the memory addresses row by row, driving the MAC valid_input/clear_acc controls, and presents each row result through a valid/ready output handshake.
- Owns only addresses and controls; data goes directly stream -> memories -> MAC.

---
 rtl/mvm_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mvm_seq_ctrl.sv
// rtl/mvm_seq_ctrl.sv - address/control sequencer for one matrix-vector multiply on a single MAC
// Optional feature macro: MVM_ROW_IDX_EN (adds out_row, the index of the row being presented)
module mvm_seq_ctrl #(
  parameter int M   = 4,
  parameter int N   = 4,
  parameter int MAW = $clog2(M * N),
  parameter int XAW = $clog2(N)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [MAW-1:0]                     addr_w,
  output logic                               wr_en_w,
  output logic [XAW-1:0]                     addr_x,
  output logic                               wr_en_x,
  output logic                               mac_valid,
  output logic                               mac_clear,
  output logic                               out_valid,
  input  logic                               out_ready,
`ifdef MVM_ROW_IDX_EN
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row,
`endif
  output logic                               busy
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [2:0] {
    LOAD_W   = 3'd0,
    LOAD_X   = 3'd1,
    COMPUTE  = 3'd2,
    DRAIN    = 3'd3,
    WAIT_OUT = 3'd4
  } state_t;

  state_t         state, state_nx;
  logic [MAW-1:0] wcnt;   // matrix words accepted so far
  logic [XAW-1:0] k;      // vector word count while loading, column while computing
  logic [RW-1:0]  r;      // current output row
  logic [MAW-1:0] rbase;  // r*N, kept incrementally so no multiplier is needed
  logic [1:0]     dcnt;   // drain cycle count
  logic           v1;     // issue pulse delayed one cycle (memory read latency)
  logic           f1, f2; // first-column flag delayed one and two cycles

  logic w_last, x_last, k_last, r_last;

  assign w_last = (wcnt == MAW'(M * N - 1));
  assign x_last = (k == XAW'(N - 1));
  assign k_last = (k == XAW'(N - 1));
  assign r_last = (r == RW'(M - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD_W;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      LOAD_W:   if (in_valid && w_last) state_nx = LOAD_X;
      LOAD_X:   if (in_valid && x_last) state_nx = COMPUTE;
      COMPUTE:  if (k_last) state_nx = DRAIN;
      DRAIN:    if (dcnt == 2'd2) state_nx = WAIT_OUT;
      WAIT_OUT: if (out_ready) state_nx = r_last ? LOAD_W : COMPUTE;
      default:  state_nx = LOAD_W;
    endcase
  end

  // Word, column, row and drain counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt  <= '0;
      k     <= '0;
      r     <= '0;
      rbase <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        LOAD_W: if (in_valid) wcnt <= w_last ? '0 : wcnt + 1'b1;
        LOAD_X: if (in_valid) k <= x_last ? '0 : k + 1'b1;
        COMPUTE: begin
          k    <= k_last ? '0 : k + 1'b1;
          dcnt <= '0;
        end
        DRAIN: dcnt <= dcnt + 2'd1;
        WAIT_OUT: begin
          if (out_ready) begin
            if (r_last) begin
              r     <= '0;
              rbase <= '0;
            end else begin
              r     <= r + 1'b1;
              rbase <= rbase + MAW'(N);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // MAC control pipeline: valid lines up with read data, clear with the first product register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      f2 <= 1'b0;
    end else begin
      v1 <= (state == COMPUTE);
      f1 <= (state == COMPUTE) && (k == '0);
      f2 <= f1;
    end
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    wr_en_w   = 1'b0;
    wr_en_x   = 1'b0;
    addr_w    = '0;
    addr_x    = '0;
    out_valid = 1'b0;
    case (state)
      LOAD_W: begin
        in_ready = 1'b1;
        wr_en_w  = in_valid;
        addr_w   = wcnt;
      end
      LOAD_X: begin
        in_ready = 1'b1;
        wr_en_x  = in_valid;
        addr_x   = k;
      end
      COMPUTE: begin
        addr_w = rbase + MAW'(k);
        addr_x = k;
      end
      WAIT_OUT: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign mac_valid = v1;
  assign mac_clear = f2;
  assign busy      = !((state == LOAD_W) && (wcnt == '0));

`ifdef MVM_ROW_IDX_EN
  assign out_row = (state == WAIT_OUT) ? r : '0;
`endif

endmodule
